cache_miss_refill: RTL

//  Miss handler for a set-associative cache: accepts one miss at a time, with victim way chosen by the PLRU.

---
 rtl/cache_miss_refill_if.sv | 58 +++++
 rtl/cache_miss_refill.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cache_miss_refill_if.sv
// Bundle between the miss handler and its neighbours: the tag-compare/PLRU
// miss request and victim info, the memory-bus bridge, and the refill write port.
interface cache_miss_refill_if #(
   parameter int unsigned ASSOC_NUM  = 4,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned TAG_W      = 20
);
   localparam int unsigned WAY_W = $clog2(ASSOC_NUM);
   localparam int unsigned IDX_W = $clog2(LINE_WORDS);

   logic                       miss_valid;
   logic                       miss_ready;
   logic [ADDR_W-1:0]          miss_addr;
   logic [WAY_W-1:0]           victim_way;
   logic                       victim_dirty;
   logic [TAG_W-1:0]           victim_tag;
   logic [32*LINE_WORDS-1:0]   victim_line;

   logic                       wr_req;
   logic                       wr_gnt;
   logic [ADDR_W-1:0]          wr_addr;
   logic                       wr_wvalid;
   logic                       wr_wready;
   logic [31:0]                wr_wdata;
   logic                       wr_wlast;
   logic                       wr_bvalid;

   logic                       rd_req;
   logic                       rd_gnt;
   logic [ADDR_W-1:0]          rd_addr;
   logic                       rd_rvalid;
   logic [31:0]                rd_rdata;

   logic [ASSOC_NUM-1:0]       refill_we;
   logic [IDX_W-1:0]           refill_widx;
   logic [31:0]                refill_wdata;
   logic                       refill_tag_we;
   logic [ASSOC_NUM-1:0]       lru_access;
   logic                       lru_update;
   logic                       done;

   modport master (
      input  miss_valid, miss_addr, victim_way, victim_dirty, victim_tag, victim_line,
      input  wr_gnt, wr_wready, wr_bvalid, rd_gnt, rd_rvalid, rd_rdata,
      output miss_ready, wr_req, wr_addr, wr_wvalid, wr_wdata, wr_wlast,
      output rd_req, rd_addr, refill_we, refill_widx, refill_wdata, refill_tag_we,
      output lru_access, lru_update, done
   );

   modport slave (
      output miss_valid, miss_addr, victim_way, victim_dirty, victim_tag, victim_line,
      output wr_gnt, wr_wready, wr_bvalid, rd_gnt, rd_rvalid, rd_rdata,
      input  miss_ready, wr_req, wr_addr, wr_wvalid, wr_wdata, wr_wlast,
      input  rd_req, rd_addr, refill_we, refill_widx, refill_wdata, refill_tag_we,
      input  lru_access, lru_update, done
   );
endinterface

// File: rtl/cache_miss_refill.sv
// Set-associative cache miss handler: optional victim writeback, line refill, PLRU touch.
// Define CACHE_MISS_PERF_EN to add the perf_miss_cnt / perf_wb_cnt counters.
module cache_miss_refill #(
   parameter int unsigned ASSOC_NUM  = 4,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned TAG_W      = 20
) (
   input  logic clk,
   input  logic resetn,
   cache_miss_refill_if.master bus
`ifdef CACHE_MISS_PERF_EN
   ,
   output logic [31:0] perf_miss_cnt,
   output logic [31:0] perf_wb_cnt
`endif
);
   localparam int unsigned WAY_W   = $clog2(ASSOC_NUM);
   localparam int unsigned CNT_W   = $clog2(LINE_WORDS);
   localparam int unsigned OFF_W   = $clog2(LINE_WORDS*4);
   localparam int unsigned LINE_W  = ADDR_W - OFF_W;
   localparam int unsigned INDEX_W = ADDR_W - TAG_W - OFF_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [LINE_W-1:0]    line_addr_q;
   logic [WAY_W-1:0]     way_q;
   logic [TAG_W-1:0]     tag_q;
   logic [31:0]          line_q [LINE_WORDS];
   logic [ASSOC_NUM-1:0] way_oh;
   logic                 accept;
   logic                 unused_offset;

   logic                 miss_ready;
   logic                 wr_req;
   logic                 wr_wvalid;
   logic [31:0]          wr_wdata;
   logic                 wr_wlast;
   logic                 rd_req;
   logic [ASSOC_NUM-1:0] refill_we;
   logic [CNT_W-1:0]     refill_widx;
   logic [31:0]          refill_wdata;
   logic                 refill_tag_we;
   logic [ASSOC_NUM-1:0] lru_access;
   logic                 lru_update;
   logic                 done;

   assign accept        = (state == IDLE) && bus.miss_valid;
   assign way_oh        = ASSOC_NUM'(1) << way_q;
   assign unused_offset = ^bus.miss_addr[OFF_W-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         line_addr_q <= '0;
         way_q       <= '0;
         tag_q       <= '0;
         for (int unsigned i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            line_addr_q <= bus.miss_addr[ADDR_W-1:OFF_W];
            way_q       <= bus.victim_way;
            tag_q       <= bus.victim_tag;
            for (int unsigned i = 0; i < LINE_WORDS; i++)
               line_q[i] <= bus.victim_line[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      miss_ready    = 1'b0;
      wr_req        = 1'b0;
      wr_wvalid     = 1'b0;
      wr_wdata      = '0;
      wr_wlast      = 1'b0;
      rd_req        = 1'b0;
      refill_we     = '0;
      refill_widx   = '0;
      refill_wdata  = '0;
      refill_tag_we = 1'b0;
      lru_access    = '0;
      lru_update    = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (bus.miss_valid) state_nxt = bus.victim_dirty ? WB_ADDR : RD_ADDR;
         end
         WB_ADDR: begin
            wr_req = 1'b1;
            if (bus.wr_gnt) state_nxt = WB_DATA;
         end
         WB_DATA: begin
            wr_wvalid = 1'b1;
            wr_wdata  = line_q[cnt];
            wr_wlast  = (cnt == CNT_LAST);
            if (bus.wr_wready) begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = WB_RESP;
               end
            end
         end
         WB_RESP: begin
            if (bus.wr_bvalid) state_nxt = RD_ADDR;
         end
         RD_ADDR: begin
            rd_req = 1'b1;
            if (bus.rd_gnt) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            // Refill beats are never back-pressured: write the data array in the beat's own cycle.
            if (bus.rd_rvalid) begin
               refill_we    = way_oh;
               refill_widx  = cnt;
               refill_wdata = bus.rd_rdata;
               cnt_nxt      = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  refill_tag_we = 1'b1;
                  cnt_nxt       = '0;
                  state_nxt     = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            lru_update = 1'b1;
            lru_access = way_oh;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.miss_ready    = miss_ready;
   assign bus.wr_req        = wr_req;
   assign bus.wr_addr       = {tag_q, line_addr_q[INDEX_W-1:0], {OFF_W{1'b0}}};
   assign bus.wr_wvalid     = wr_wvalid;
   assign bus.wr_wdata      = wr_wdata;
   assign bus.wr_wlast      = wr_wlast;
   assign bus.rd_req        = rd_req;
   assign bus.rd_addr       = {line_addr_q, {OFF_W{1'b0}}};
   assign bus.refill_we     = refill_we;
   assign bus.refill_widx   = refill_widx;
   assign bus.refill_wdata  = refill_wdata;
   assign bus.refill_tag_we = refill_tag_we;
   assign bus.lru_access    = lru_access;
   assign bus.lru_update    = lru_update;
   assign bus.done          = done;

`ifdef CACHE_MISS_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_miss_cnt <= '0;
         perf_wb_cnt   <= '0;
      end else if (accept) begin
         perf_miss_cnt <= perf_miss_cnt + 32'd1;
         if (bus.victim_dirty) perf_wb_cnt <= perf_wb_cnt + 32'd1;
      end
   end
`endif

endmodule
